// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous pattern selector: debounced buttons, manual/auto/override modes,
// pattern changes only at the start of vertical blank. Optional macro: SEQ_TYPING_EN.

module vga_pattern_sequencer_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk_25MHz,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [1:0]   sync;
  logic [W-1:0] cnt;
  logic         accept;

  // accept fires on the CYCLES-th consecutive sample that disagrees with level
  assign accept = (sync[1] != level) && (cnt == LAST);
  assign rise   = accept & sync[1];

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level || accept) cnt <= '0;
      else                            cnt <= cnt + 1'b1;
      if (accept) level <= sync[1];
    end
  end
endmodule

module vga_pattern_sequencer #(
  parameter int V_ACTIVE        = 480,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic [1:0]  sw,
  input  logic        btnL,
  input  logic        btnC,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic [2:0]  pattern_sel,
  output logic [1:0]  mode,
  output logic        frame_tick
);
  localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(AUTO_FRAMES - 1);

  typedef enum logic [1:0] {MANUAL = 2'd0, AUTO = 2'd1, OVERRIDE = 2'd2} state_t;

  logic [1:0]    sw_s1, sw_s2;
  logic [1:0]    lvl, rise;
  state_t        state_q, state_nxt;
  logic [2:0]    sel_q, sel_nxt;
  logic [2:0]    idx_q, idx_nxt;
  logic [FW-1:0] fcnt_q, fcnt_nxt, fcnt_base;
  logic          auto_q, auto_nxt;
  logic          tick_q, boundary;

  // lane 0 = btnL (override), lane 1 = btnC (auto toggle)
  for (genvar g = 0; g < 2; g++) begin : g_db
    vga_pattern_sequencer_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_25MHz(clk_25MHz),
      .reset    (reset),
      .raw      (g == 0 ? btnL : btnC),
      .level    (lvl[g]),
      .rise     (rise[g])
    );
  end

  function automatic logic [2:0] rot_next(input logic [2:0] i);
`ifdef SEQ_TYPING_EN
    case (i)
      3'd3:    return 3'd5;
      3'd5:    return 3'd0;
      default: return i + 3'd1;
    endcase
`else
    return (i == 3'd3) ? 3'd0 : i + 3'd1;
`endif
  endfunction

  always_comb begin
    boundary  = (hcount == 11'd0) && (vcount == 11'(V_ACTIVE));
    auto_nxt  = auto_q ^ rise[1];
    fcnt_base = (rise[1] && !auto_q) ? '0 : fcnt_q;
    fcnt_nxt  = fcnt_base;
    idx_nxt   = idx_q;
    state_nxt = state_q;
    sel_nxt   = sel_q;
    if (boundary) begin
      if (lvl[0]) begin
        state_nxt = OVERRIDE;
        sel_nxt   = 3'd4;
      end else if (auto_nxt) begin
        state_nxt = AUTO;
        if (fcnt_base == F_LAST) begin
          fcnt_nxt = '0;
          idx_nxt  = rot_next(idx_q);
        end else begin
          fcnt_nxt = fcnt_base + 1'b1;
        end
        sel_nxt = idx_nxt;
      end else begin
        state_nxt = MANUAL;
        sel_nxt   = {1'b0, sw_s2};
      end
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      state_q <= MANUAL;
      sel_q   <= '0;
      idx_q   <= '0;
      fcnt_q  <= '0;
      auto_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sw_s1   <= sw;
      sw_s2   <= sw_s1;
      state_q <= state_nxt;
      sel_q   <= sel_nxt;
      idx_q   <= idx_nxt;
      fcnt_q  <= fcnt_nxt;
      auto_q  <= auto_nxt;
      tick_q  <= boundary;
    end
  end

  assign pattern_sel = sel_q;
  assign mode        = state_q;
  assign frame_tick  = tick_q;
endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Randomized + directed bench for vga_pattern_sequencer against a sample-history reference model.
module tb_vga_pattern_sequencer;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int HT = 10;
  localparam int VT = 8;
  localparam int VA = 6;

  logic        clk_25MHz = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  sw = 2'd0;
  logic        btnL = 1'b0, btnC = 1'b0;
  logic [10:0] hcount = '0, vcount = '0;
  logic [2:0]  pattern_sel;
  logic [1:0]  mode;
  logic        frame_tick;

  vga_pattern_sequencer #(.V_ACTIVE(VA), .DEBOUNCE_CYCLES(D), .AUTO_FRAMES(AF)) dut (
    .clk_25MHz(clk_25MHz), .reset(reset), .sw(sw), .btnL(btnL), .btnC(btnC),
    .hcount(hcount), .vcount(vcount),
    .pattern_sel(pattern_sel), .mode(mode), .frame_tick(frame_tick)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  int n_checks = 0, n_err = 0;
  int hc = 0, vc = 0;

  // reference model: raw sample histories (index 0 = newest) and abstract state
`ifdef SEQ_TYPING_EN
  int m_seq[$] = '{0, 1, 2, 3, 5};
`else
  int m_seq[$] = '{0, 1, 2, 3};
`endif
  logic       rl [0:D+1];
  logic       rc [0:D+1];
  logic [1:0] rs [0:D+1];
  logic       m_dbL, m_dbC, m_auto, m_tick;
  int         m_fcnt, m_pos;
  logic [2:0] m_sel;
  logic [1:0] m_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // a level is accepted once the last D synchronised samples all agree and differ from it
  function automatic logic stable(input logic h [0:D+1]);
    for (int i = 3; i <= D + 1; i++) if (h[i] != h[2]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic acc_l, acc_c, bnd, old_l;
    for (int i = D + 1; i > 0; i--) begin
      rl[i] = rl[i-1]; rc[i] = rc[i-1]; rs[i] = rs[i-1];
    end
    rl[0] = btnL; rc[0] = btnC; rs[0] = sw;
    if (reset) begin
      for (int i = 0; i <= D + 1; i++) begin rl[i] = 0; rc[i] = 0; rs[i] = 0; end
      m_dbL = 0; m_dbC = 0; m_auto = 0; m_tick = 0;
      m_fcnt = 0; m_pos = 0; m_sel = 0; m_mode = 0;
      return;
    end
    acc_l = stable(rl) && (rl[2] != m_dbL);
    acc_c = stable(rc) && (rc[2] != m_dbC);
    bnd   = (hcount == 0) && (vcount == VA);
    old_l = m_dbL;
    if (acc_c && rc[2]) begin
      m_auto = !m_auto;
      if (m_auto) m_fcnt = 0;
    end
    if (bnd) begin
      if (old_l) begin
        m_sel = 3'd4; m_mode = 2'd2;
      end else if (m_auto) begin
        m_fcnt++;
        if (m_fcnt == AF) begin m_fcnt = 0; m_pos = (m_pos + 1) % m_seq.size(); end
        m_sel = 3'(m_seq[m_pos]); m_mode = 2'd1;
      end else begin
        m_sel = {1'b0, rs[2]}; m_mode = 2'd0;
      end
    end
    m_tick = bnd;
    if (acc_l) m_dbL = rl[2];
    if (acc_c) m_dbC = rc[2];
  endtask

  task automatic cyc();
    hcount = 11'(hc); vcount = 11'(vc);
    model_edge();
    @(posedge clk_25MHz); #1;
    check("cycle", {26'd0, pattern_sel, mode, frame_tick}, {26'd0, m_sel, m_mode, m_tick});
    hc++;
    if (hc == HT) begin hc = 0; vc = (vc + 1) % VT; end
    @(negedge clk_25MHz);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_to_tick();
    logic seen = 0;
    for (int i = 0; i < 2 * HT * VT && !seen; i++) begin
      cyc();
      seen = m_tick;
    end
    check("tick_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic press_c();
    btnC = 1; run(D + 4);
    btnC = 0; run(D + 4);
  endtask

  initial begin
    reset = 1; run(3);
    reset = 0; run(5);
    check("rst_mode", {30'd0, mode}, 32'd0);

    // reset mid-frame with sw=3
    sw = 2'b11; run(HT * 3);
    reset = 1; cyc();
    check("rst_sel", {29'd0, pattern_sel}, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
    reset = 0;
    run_to_tick();
    check("rst_sw3", {29'd0, pattern_sel}, 32'd3);
    cyc();
    check("tick_1cyc", {31'd0, frame_tick}, 32'd0);

    // manual timing
    sw = 2'b00; run_to_tick(); run(HT * 2);
    sw = 2'b10; run(HT * 2);
    check("man_hold", {29'd0, pattern_sel}, 32'd0);
    run_to_tick();
    check("man_sel", {29'd0, pattern_sel}, 32'd2);

    // debounce: 3-cycle glitch then a stable run
    btnC = 1; run(3); btnC = 0; run(1);
    btnC = 1; run(6); btnC = 0; run(D + 4);
    check("dbc_wait", {30'd0, mode}, 32'd0);
    run_to_tick();
    check("dbc_mode", {30'd0, mode}, 32'd1);

    // auto rotation over a dozen frames
    for (int f = 0; f < 12; f++) run_to_tick();
    check("auto_mode", {30'd0, mode}, 32'd1);

    // override from rotation index 2
    for (int f = 0; f < 40 && !(m_pos == 2 && m_fcnt == 0); f++) run_to_tick();
    check("pos2", m_pos, 32'd2);
    btnL = 1; run(D + 4);
    for (int f = 0; f < 4; f++) begin
      run_to_tick();
      check("ovr_sel", {29'd0, pattern_sel}, 32'd4);
      check("ovr_mode", {30'd0, mode}, 32'd2);
    end
    btnL = 0; run(D + 4);
    run_to_tick();
    check("rel_sel", {29'd0, pattern_sel}, 32'd2);
    check("rel_mode", {30'd0, mode}, 32'd1);

    // toggle btnC while override is held
    btnL = 1; run(D + 4); run_to_tick();
    press_c();
    run_to_tick();
    check("sim_sel", {29'd0, pattern_sel}, 32'd4);
    btnL = 0; run(D + 4); run_to_tick();
    check("sim_mode", {30'd0, mode}, 32'd0);
    check("sim_sw", {29'd0, pattern_sel}, {30'd0, sw});

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 59) == 0) sw = 2'($urandom);
      if ($urandom_range(0, 6) == 0) btnC = ~btnC;
      if ($urandom_range(0, 39) == 0) btnL = ~btnL;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
